// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin server for the core instruction bus; grants one sender
// per transaction and delivers its message to a unicast or broadcast destination mask.
module bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int INSTR_WIDTH = 2,
    localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CORES-1:0]               send_req,
    input  logic [NUM_CORES-1:0]               broadcast_mode,
    input  logic [NUM_CORES*CORE_ID_WIDTH-1:0] dst_ids,
    input  logic [NUM_CORES*INSTR_WIDTH-1:0]   instructions,
    input  logic [NUM_CORES-1:0]               core_enable,
    output logic [NUM_CORES-1:0]               send_grant,
    output logic [NUM_CORES-1:0]               recv_valid,
    output logic [CORE_ID_WIDTH-1:0]           src_id,
    output logic [INSTR_WIDTH-1:0]             instruction,
    output logic [7:0]                         drop_count
);
    typedef enum logic {IDLE, DELIVER} state_t;
    state_t state, next_state;
    logic [CORE_ID_WIDTH-1:0] rr_ptr, winner, dst;
    logic [NUM_CORES-1:0] eff, mask;
    logic found;
    int idx;
    always_comb begin
        eff = send_req & core_enable;
        winner = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            if (!found && eff[idx]) begin
                found = 1'b1;
                winner = CORE_ID_WIDTH'(idx);
            end
        end
        dst = dst_ids[int'(winner)*CORE_ID_WIDTH +: CORE_ID_WIDTH];
        mask = '0;
        if (broadcast_mode[winner]) begin
            mask = core_enable;
            mask[winner] = 1'b0;
        end else if (int'(dst) < NUM_CORES && dst != winner && core_enable[dst]) begin
            mask[dst] = 1'b1;
        end
        next_state = (state == IDLE && found) ? DELIVER : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            send_grant <= '0;
            recv_valid <= '0;
            src_id <= '0;
            instruction <= '0;
            drop_count <= '0;
        end else begin
            state <= next_state;
            send_grant <= '0;
            recv_valid <= '0;
            if (state == IDLE && found) begin
                send_grant <= NUM_CORES'(1) << winner;
                recv_valid <= mask;
                src_id <= winner;
                instruction <= instructions[int'(winner)*INSTR_WIDTH +: INSTR_WIDTH];
                rr_ptr <= CORE_ID_WIDTH'((int'(winner) + 1) % NUM_CORES);
            end
            // a delivery that reached nobody is a drop
            if (state == DELIVER && recv_valid == '0 && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table plus hand-written sequences; expected deliveries are
// queued when requests are driven and checked whenever the DUT raises a grant.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] send_req = 4'b1111, broadcast_mode = '0, core_enable = 4'b1111;
    logic [7:0] dst_ids = '0, instructions = '0;
    logic [3:0] send_grant, recv_valid;
    logic [1:0] src_id, instruction;
    logic [7:0] drop_count;
    int n_cmp = 0, n_err = 0, drops = 0;

    typedef struct { logic [3:0] grant, valid; logic [1:0] src, instr; } exp_t;
    typedef struct { logic [3:0] en; int core; logic bc; logic [1:0] dst, instr; logic [3:0] valid; } vec_t;
    exp_t exp_q[$];
    vec_t vecs[8];

    bus_arbiter dut (
        .clk(clk), .rst_n(rst_n), .send_req(send_req), .broadcast_mode(broadcast_mode),
        .dst_ids(dst_ids), .instructions(instructions), .core_enable(core_enable),
        .send_grant(send_grant), .recv_valid(recv_valid), .src_id(src_id),
        .instruction(instruction), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_msg(int core, logic [1:0] instr, logic [3:0] valid);
        exp_t e;
        e.grant = 4'(1 << core);
        e.valid = valid;
        e.src = 2'(core);
        e.instr = instr;
        exp_q.push_back(e);
        if (valid == 4'b0000 && drops < 255) drops++;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (send_grant != 4'b0000) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_grant: got grant=%b valid=%b src=%0d", send_grant, recv_valid, src_id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({send_grant, recv_valid, src_id, instruction} !== {e.grant, e.valid, e.src, e.instr}) begin
                        n_err++;
                        $display("FAIL delivery: got grant=%b valid=%b src=%0d instr=%b expected grant=%b valid=%b src=%0d instr=%b",
                                 send_grant, recv_valid, src_id, instruction, e.grant, e.valid, e.src, e.instr);
                    end
                end
            end else if (recv_valid != 4'b0000) begin
                n_cmp++;
                n_err++;
                $display("FAIL valid_without_grant: got valid=%b expected 0000", recv_valid);
            end
        end
    end

    task automatic run_vec(vec_t v);
        core_enable = v.en;
        send_req = 4'(1 << v.core);
        broadcast_mode = v.bc ? 4'(1 << v.core) : 4'b0000;
        dst_ids = '0;
        dst_ids[v.core*2 +: 2] = v.dst;
        instructions = '0;
        instructions[v.core*2 +: 2] = v.instr;
        expect_msg(v.core, v.instr, v.valid);
        @(negedge clk);
        send_req = '0;
        @(negedge clk);
        check("idle_grant", 32'(send_grant), 0);
        check("drop_count", 32'(drop_count), 32'(drops));
    endtask

    initial begin
        vecs[0] = '{4'b1111, 2, 1'b0, 2'd1, 2'b10, 4'b0010};
        vecs[1] = '{4'b1011, 3, 1'b1, 2'd0, 2'b01, 4'b0011};
        vecs[2] = '{4'b1111, 1, 1'b0, 2'd1, 2'b11, 4'b0000};
        vecs[3] = '{4'b1011, 1, 1'b0, 2'd2, 2'b00, 4'b0000};
        vecs[4] = '{4'b1111, 0, 1'b1, 2'd0, 2'b11, 4'b1110};
        vecs[5] = '{4'b1111, 3, 1'b0, 2'd0, 2'b00, 4'b0001};
        vecs[6] = '{4'b0111, 1, 1'b1, 2'd3, 2'b10, 4'b0101};
        vecs[7] = '{4'b1111, 0, 1'b0, 2'd3, 2'b01, 4'b1000};
        dst_ids = {2'd0, 2'd3, 2'd2, 2'd1};
        instructions = {2'd3, 2'd2, 2'd1, 2'd0};
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(send_grant), 0);
        check("rst_valid", 32'(recv_valid), 0);
        check("rst_src", 32'(src_id), 0);
        check("rst_instr", 32'(instruction), 0);
        check("rst_drop", 32'(drop_count), 0);
        rst_n = 1'b1;
        check("release_grant", 32'(send_grant), 0);
        check("release_valid", 32'(recv_valid), 0);
        for (int i = 0; i < 5; i++) expect_msg(i % 4, 2'(i % 4), 4'(1 << ((i + 1) % 4)));
        repeat (9) @(negedge clk);
        send_req = '0;
        @(negedge clk);
        check("rotation_done", 32'(exp_q.size()), 0);
        drops = 0;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        check("after_drops", 32'(drop_count), 2);
        core_enable = 4'b1011;
        broadcast_mode = 4'b1000;
        instructions = 8'b01_00_00_00;
        send_req = 4'b1100;
        expect_msg(3, 2'b01, 4'b0011);
        @(negedge clk);
        send_req = 4'b0100;
        repeat (6) @(negedge clk);
        send_req = '0;
        check("masked_core_done", 32'(exp_q.size()), 0);
        core_enable = 4'b1111;
        broadcast_mode = '0;
        dst_ids = {2'd0, 2'd0, 2'd2, 2'd0};
        instructions = {2'b10, 2'b11, 2'b01, 2'b00};
        send_req = 4'b0100;
        expect_msg(2, 2'b11, 4'b0001);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_grant", 32'(send_grant), 0);
        check("midrst_valid", 32'(recv_valid), 0);
        check("midrst_src", 32'(src_id), 0);
        check("midrst_instr", 32'(instruction), 0);
        drops = 0;
        send_req = 4'b1010;
        rst_n = 1'b1;
        expect_msg(1, 2'b01, 4'b0100);
        expect_msg(3, 2'b10, 4'b0001);
        @(negedge clk);
        send_req = 4'b1000;
        repeat (2) @(negedge clk);
        send_req = '0;
        @(negedge clk);
        check("midrst_done", 32'(exp_q.size()), 0);
        dst_ids = {2'd0, 2'd0, 2'd1, 2'd0};
        for (int i = 0; i < 300; i++) expect_msg(1, 2'b01, 4'b0000);
        send_req = 4'b0010;
        repeat (599) @(negedge clk);
        send_req = '0;
        @(negedge clk);
        check("drop_saturate", 32'(drop_count), 255);
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
